// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: access-size encodings,
// FSM state encodings and the data bus width.
package mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering for big-endian accesses. Lane k always refers to
// byte address a+k, so lane 0 carries the most significant byte of the
// access. Also flags accesses that are not naturally aligned.
module mem_lane_steer
  import mem_pkg::*;
(
  input  logic [1:0]        dtype,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       wdata,
  input  logic [3:0][7:0]   rbyte,
  output logic [3:0]        we,
  output logic [3:0][7:0]   wbyte,
  output logic [31:0]       rdata,
  output logic              misal
);

  // Decode access size into lane enables, write bytes and read assembly
  always_comb begin
    we    = 4'b0000;
    wbyte = '0;
    rdata = '0;
    misal = 1'b0;
    case (dtype)
      DT_BYTE: begin
        we       = 4'b0001;
        wbyte[0] = wdata[7:0];
        rdata    = {24'b0, rbyte[0]};
      end
      DT_HALF: begin
        we       = 4'b0011;
        wbyte[0] = wdata[15:8];
        wbyte[1] = wdata[7:0];
        rdata    = {16'b0, rbyte[0], rbyte[1]};
        misal    = addr_lo[0];
      end
      default: begin
        we       = 4'b1111;
        wbyte[0] = wdata[31:24];
        wbyte[1] = wdata[23:16];
        wbyte[2] = wdata[15:8];
        wbyte[3] = wdata[7:0];
        rdata    = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
        misal    = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MFA/MOC handshake. Captures a request,
// waits LATENCY cycles, commits it on a byte-addressed big-endian array
// and raises moc until mfa is released.
// Optional feature macro: MEM_ALIGN_CHECK_EN (adds align_err and blocks
// misaligned half/word accesses).
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mfa,
  input  logic                  rw,
  input  logic [1:0]            dtype,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  align_err
`endif
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  req_rw;
  logic [1:0]            req_dtype;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] lane_addr [4];
  logic [3:0][7:0]       rbyte;
  logic [3:0]            we;
  logic [3:0][7:0]       wbyte;
  logic [31:0]           rdata;
  logic                  misal;
  logic                  blocked;
  logic                  commit;

  assign commit = (state == ST_BUSY) && (cnt == 4'd0);

`ifdef MEM_ALIGN_CHECK_EN
  assign blocked = misal;
`else
  logic unused_misal;
  assign unused_misal = misal;
  assign blocked      = 1'b0;
`endif

  // Lane addresses wrap modulo the array size; read all four lanes
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = req_addr + ADDR_WIDTH'(k);
      rbyte[k]     = mem[lane_addr[k]];
    end
  end

  mem_lane_steer u_steer (
    .dtype   (req_dtype),
    .addr_lo (req_addr[1:0]),
    .wdata   (req_data),
    .rbyte   (rbyte),
    .we      (we),
    .wbyte   (wbyte),
    .rdata   (rdata),
    .misal   (misal)
  );

  // Latch the request when it is accepted; ignored afterwards
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && mfa) begin
      req_rw    <= rw;
      req_dtype <= dtype;
      req_addr  <= addr;
      req_data  <= data_in;
    end
  end

  // Array write at commit; contents survive reset
  always_ff @(posedge clk) begin
    if (commit && !reset && !req_rw && !blocked) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem[lane_addr[k]] <= wbyte[k];
      end
    end
  end

  // Handshake FSM, latency counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      moc      <= 1'b0;
      data_out <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (mfa) begin
            state <= ST_BUSY;
            cnt   <= LAT_M1;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            state <= ST_DONE;
            moc   <= 1'b1;
            if (req_rw && !blocked) data_out <= rdata;
`ifdef MEM_ALIGN_CHECK_EN
            align_err <= blocked;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!mfa) begin
            state <= ST_IDLE;
            moc   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_WIDTH=9, LATENCY=2).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mfa = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  dtype = 2'b00;
  logic [8:0]  addr = 9'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        moc;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic last_ae = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(9), .LATENCY(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .mfa      (mfa),
    .rw       (rw),
    .dtype    (dtype),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .moc      (moc)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .align_err(align_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One handshake; hold>0 keeps mfa high that many cycles after moc.
  // Inputs are scrambled after acceptance to show they are ignored.
  task automatic access(input string tag, input logic r, input logic [1:0] dt,
                        input logic [8:0] a, input logic [31:0] d, input int hold);
    int n;
    @(negedge clk);
    mfa = 1'b1; rw = r; dtype = dt; addr = a; data_in = d;
    @(posedge clk);
    #1;
    addr = a ^ 9'h155; data_in = ~d; rw = ~r; dtype = ~dt;
    if (hold == 0) mfa = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!moc && n < 20);
    check({tag, "_lat"}, n, 2);
`ifdef MEM_ALIGN_CHECK_EN
    last_ae = align_err;
`endif
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_moc"}, {31'd0, moc}, 32'd1);
      end
      @(negedge clk); mfa = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, "_moc_drop"}, {31'd0, moc}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [1:0] dt, input logic [8:0] a,
                    input logic [31:0] exp);
    access(tag, 1'b1, dt, a, 32'h0, 0);
    check(tag, data_out, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_moc", {31'd0, moc}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Word write / read, sub-word reads
    access("wr_word", 1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 0);
    rd("rd_word", 2'b10, 9'h010, 32'hDEADBEEF);
    rd("rd_byte", 2'b00, 9'h011, 32'h000000AD);
    rd("rd_half", 2'b01, 9'h012, 32'h0000BEEF);
    rd("rd_dt11", 2'b11, 9'h010, 32'hDEADBEEF);

    // Merge of word, half and byte writes; writes leave data_out alone
    access("m_w", 1'b0, 2'b10, 9'h020, 32'h11223344, 0);
    access("m_h", 1'b0, 2'b01, 9'h022, 32'h0000AABB, 0);
    access("m_b", 1'b0, 2'b00, 9'h020, 32'h000000CC, 0);
    check("wr_keeps_dout", data_out, 32'hDEADBEEF);
    rd("rd_merge", 2'b10, 9'h020, 32'hCC22AABB);

    // Handshake hold, then immediate re-request
    access("hold", 1'b0, 2'b00, 9'h030, 32'h00000055, 5);
    rd("rd_after_hold", 2'b00, 9'h030, 32'h00000055);

    // Address wrap at the top of the array
    access("wrap_w", 1'b0, 2'b10, 9'h1FE, 32'h01020304, 0);
    rd("wrap_1fe", 2'b00, 9'h1FE, 32'h00000001);
    rd("wrap_1ff", 2'b00, 9'h1FF, 32'h00000002);
    rd("wrap_000", 2'b00, 9'h000, 32'h00000003);
    rd("wrap_001", 2'b00, 9'h001, 32'h00000004);
    rd("wrap_word", 2'b10, 9'h1FE, 32'h01020304);

    // Reset in the middle of a write aborts it
    access("pre_w", 1'b0, 2'b10, 9'h040, 32'h12345678, 0);
    rd("pre_rd", 2'b10, 9'h040, 32'h12345678);
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; dtype = 2'b10; addr = 9'h040; data_in = 32'hFFFFFFFF;
    @(posedge clk);
    @(posedge clk);
    #1; reset = 1'b1; mfa = 1'b0;
    #1;
    check("abort_moc", {31'd0, moc}, 32'd0);
    check("abort_dout", data_out, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_idle_moc", {31'd0, moc}, 32'd0);
    rd("abort_rd", 2'b10, 9'h040, 32'h12345678);

    // Misaligned word write
    access("mis_w", 1'b0, 2'b10, 9'h041, 32'hFFFFFFFF, 0);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_align_err", {31'd0, last_ae}, 32'd1);
    check("mis_err_clear", {31'd0, align_err}, 32'd0);
    check("mis_dout_kept", data_out, 32'h12345678);
    rd("mis_mem", 2'b10, 9'h040, 32'h12345678);
    check("ok_align_err", {31'd0, last_ae}, 32'd0);
`else
    rd("mis_mem", 2'b10, 9'h040, 32'h12FFFFFF);
    rd("mis_044", 2'b00, 9'h044, 32'h000000FF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
